// File: rtl/secuencia_lectura_rtc.sv
// secuencia_lectura_rtc
// Step sequencer for the RTC read-transfer decoder. A start request walks the
// decoder step address through 1..LAST_STEP, holding each step for
// TICKS_PER_STEP clocks. On the last tick of each field's step the returned
// byte is latched. The result is a stable snapshot of time, date and timer
// bytes, followed by a one-cycle done pulse.
module secuencia_lectura_rtc #(
    parameter int TICKS_PER_STEP = 4,
    parameter int LAST_STEP      = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [5:0] addr,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic       data_valid,
    input  logic [7:0] s_in,
    input  logic [7:0] m_in,
    input  logic [7:0] h_in,
    input  logic [7:0] d_in,
    input  logic [7:0] me_in,
    input  logic [7:0] a_in,
    input  logic [7:0] st_in,
    input  logic [7:0] mt_in,
    input  logic [7:0] ht_in,
    output logic [7:0] s,
    output logic [7:0] m,
    output logic [7:0] h,
    output logic [7:0] d,
    output logic [7:0] me,
    output logic [7:0] a,
    output logic [7:0] st,
    output logic [7:0] mt,
    output logic [7:0] ht
);

    // The tick counter only has to reach TICKS_PER_STEP-1; keep at least one
    // bit so a single-tick build still has a legal vector.
    localparam int TICK_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
    localparam logic [5:0]        ADDR_LAST = 6'(LAST_STEP);

    // Decoder step at which each field byte is presented on the bus.
    localparam logic [5:0] STEP_S  = 6'd10;
    localparam logic [5:0] STEP_M  = 6'd15;
    localparam logic [5:0] STEP_H  = 6'd20;
    localparam logic [5:0] STEP_D  = 6'd25;
    localparam logic [5:0] STEP_ME = 6'd30;
    localparam logic [5:0] STEP_A  = 6'd35;
    localparam logic [5:0] STEP_ST = 6'd40;
    localparam logic [5:0] STEP_MT = 6'd45;
    localparam logic [5:0] STEP_HT = 6'd50;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic              step_end;

    // Last tick of the current step: the decoder bus has had the longest
    // possible time to settle, so this is where fields are sampled.
    assign step_end = (tick == TICK_LAST);

    // Sequencer FSM with registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tick       <= '0;
            addr       <= 6'd0;
            en         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tick <= '0;
                    if (start) begin
                        state <= RUN;
                        addr  <= 6'd1;
                        en    <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (step_end) begin
                        tick <= '0;
                        if (addr == ADDR_LAST) begin
                            // Last step consumed: drop the decoder and report.
                            state      <= DONE;
                            addr       <= 6'd0;
                            en         <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            data_valid <= 1'b1;
                        end else begin
                            addr <= addr + 6'd1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here, so a held
                    // request always leaves exactly one idle cycle.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    addr  <= 6'd0;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Snapshot registers: load the raw field byte at the end of its step,
    // otherwise hold across idle periods and later sequences.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s  <= 8'h00;
            m  <= 8'h00;
            h  <= 8'h00;
            d  <= 8'h00;
            me <= 8'h00;
            a  <= 8'h00;
            st <= 8'h00;
            mt <= 8'h00;
            ht <= 8'h00;
        end else if ((state == RUN) && step_end) begin
            case (addr)
                STEP_S:  s  <= s_in;
                STEP_M:  m  <= m_in;
                STEP_H:  h  <= h_in;
                STEP_D:  d  <= d_in;
                STEP_ME: me <= me_in;
                STEP_A:  a  <= a_in;
                STEP_ST: st <= st_in;
                STEP_MT: mt <= mt_in;
                STEP_HT: ht <= ht_in;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_secuencia_lectura_rtc.sv
// Testbench for secuencia_lectura_rtc: default build (4 ticks/step) and a
// single-tick build, both fed by a decoder model that only returns the true
// field byte on the last tick of its step (0xFF before that, 0x00 elsewhere).
module tb_secuencia_lectura_rtc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Field order: s, m, h, d, me, a, st, mt, ht (steps 10,15,...,50).
    logic [7:0] expv [9] = '{8'h45, 8'h30, 8'h12, 8'h21, 8'h06, 8'h16, 8'h10, 8'h05, 8'h01};

    // ---------------- instance 0: default parameters ----------------
    logic       start0 = 1'b0;
    logic [5:0] addr0;
    logic       en0, busy0, done0, dv0;
    logic [7:0] fin0  [9];
    logic [7:0] snap0 [9];

    secuencia_lectura_rtc #(.TICKS_PER_STEP(4), .LAST_STEP(50)) u0 (
        .clk(clk), .rst(rst), .start(start0),
        .addr(addr0), .en(en0), .busy(busy0), .done(done0), .data_valid(dv0),
        .s_in(fin0[0]), .m_in(fin0[1]), .h_in(fin0[2]), .d_in(fin0[3]), .me_in(fin0[4]),
        .a_in(fin0[5]), .st_in(fin0[6]), .mt_in(fin0[7]), .ht_in(fin0[8]),
        .s(snap0[0]), .m(snap0[1]), .h(snap0[2]), .d(snap0[3]), .me(snap0[4]),
        .a(snap0[5]), .st(snap0[6]), .mt(snap0[7]), .ht(snap0[8])
    );

    // ---------------- instance 1: one tick per step ----------------
    logic       start1 = 1'b0;
    logic [5:0] addr1;
    logic       en1, busy1, done1, dv1;
    logic [7:0] fin1  [9];
    logic [7:0] snap1 [9];

    secuencia_lectura_rtc #(.TICKS_PER_STEP(1), .LAST_STEP(50)) u1 (
        .clk(clk), .rst(rst), .start(start1),
        .addr(addr1), .en(en1), .busy(busy1), .done(done1), .data_valid(dv1),
        .s_in(fin1[0]), .m_in(fin1[1]), .h_in(fin1[2]), .d_in(fin1[3]), .me_in(fin1[4]),
        .a_in(fin1[5]), .st_in(fin1[6]), .mt_in(fin1[7]), .ht_in(fin1[8]),
        .s(snap1[0]), .m(snap1[1]), .h(snap1[2]), .d(snap1[3]), .me(snap1[4]),
        .a(snap1[5]), .st(snap1[6]), .mt(snap1[7]), .ht(snap1[8])
    );

    // Cycles the current address has been held (0 in the first cycle of a step).
    logic [5:0] last0 = 6'd0, last1 = 6'd0;
    int         held0 = 0, held1 = 0;
    always @(negedge clk) begin
        held0 <= (addr0 != last0) ? 0 : held0 + 1;
        last0 <= addr0;
        held1 <= (addr1 != last1) ? 0 : held1 + 1;
        last1 <= addr1;
    end

    function automatic logic [7:0] dec(input logic [5:0] ad, input int held, input int tps,
                                       input int step, input logic [7:0] v);
        if (int'(ad) == step) return (held == tps - 1) ? v : 8'hFF;
        return 8'h00;
    endfunction

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            fin0[i] = dec(addr0, held0, 4, 10 + 5 * i, expv[i]);
            fin1[i] = dec(addr1, held1, 1, 10 + 5 * i, expv[i]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_snap0(input string tag, input logic zero);
        for (int i = 0; i < 9; i++)
            check($sformatf("%s_snap%0d", tag, i), 32'(snap0[i]), zero ? 32'h0 : 32'(expv[i]));
    endtask

    // Control outputs of instance 0 at selected cycles of a sequence.
    // n = number of clock edges after the edge that samples start.
    typedef struct {
        int         n;
        logic [5:0] addr;
        logic       en;
        logic       busy;
        logic       done;
    } vec_t;
    vec_t vec [8];

    // Full read on instance 0 with table checks; optionally re-pulse start at mid_n.
    task automatic run_full(input string tag, input int mid_n, input logic dv_before);
        int done_cnt = 0;
        int done_at  = -1;
        int hold_bad = 0;
        int idle_bad = 0;
        int vi       = 0;
        start0 = 1'b1;
        for (int n = 0; n <= 230; n++) begin
            @(negedge clk);
            if (n == 0) start0 = 1'b0;
            if (n == mid_n) start0 = 1'b1;
            if (n == mid_n + 1) start0 = 1'b0;
            if (n == 0) check({tag, "_dv_before"}, 32'(dv0), 32'(dv_before));
            if (n < 200 && (addr0 != 6'(n / 4 + 1) || en0 !== 1'b1 || busy0 !== 1'b1)) hold_bad++;
            if (n > 200 && (addr0 != 6'd0 || en0 !== 1'b0 || busy0 !== 1'b0)) idle_bad++;
            if (done0 === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (vi < 8 && vec[vi].n == n) begin
                check($sformatf("%s_vec_n%0d", tag, n),
                      32'({addr0, en0, busy0, done0}),
                      32'({vec[vi].addr, vec[vi].en, vec[vi].busy, vec[vi].done}));
                vi++;
            end
            if (n == 200 || n == 230) check($sformatf("%s_dv_n%0d", tag, n), 32'(dv0), 32'h1);
        end
        check({tag, "_addr_hold"}, 32'(hold_bad), 32'h0);
        check({tag, "_idle_after"}, 32'(idle_bad), 32'h0);
        check({tag, "_done_count"}, 32'(done_cnt), 32'h1);
        check({tag, "_done_at"}, 32'(done_at), 32'd200);
        check_snap0(tag, 1'b0);
    endtask

    initial begin
        vec[0] = '{0,   6'd1,  1'b1, 1'b1, 1'b0};
        vec[1] = '{3,   6'd1,  1'b1, 1'b1, 1'b0};
        vec[2] = '{4,   6'd2,  1'b1, 1'b1, 1'b0};
        vec[3] = '{39,  6'd10, 1'b1, 1'b1, 1'b0};
        vec[4] = '{40,  6'd11, 1'b1, 1'b1, 1'b0};
        vec[5] = '{199, 6'd50, 1'b1, 1'b1, 1'b0};
        vec[6] = '{200, 6'd0,  1'b0, 1'b0, 1'b1};
        vec[7] = '{201, 6'd0,  1'b0, 1'b0, 1'b0};

        // 1. reset, then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_ctrl0", 32'({addr0, en0, busy0, done0, dv0}), 32'h0);
        check("rst_ctrl1", 32'({addr1, en1, busy1, done1, dv1}), 32'h0);
        check_snap0("rst", 1'b1);
        for (int i = 0; i < 9; i++) check($sformatf("rst1_snap%0d", i), 32'(snap1[i]), 32'h0);

        // 2. first read
        run_full("read1", -10, 1'b0);

        // 3. start re-pulsed during step 20 is ignored
        run_full("midstart", 76, 1'b1);

        // 4. asynchronous reset during step 30, then a fresh read
        start0 = 1'b1;
        for (int n = 0; n <= 117; n++) begin
            @(negedge clk);
            if (n == 0) start0 = 1'b0;
        end
        check("pre_rst_addr", 32'(addr0), 32'd30);
        rst = 1'b1;
        #1;
        check("async_rst_ctrl", 32'({addr0, en0, busy0, done0, dv0}), 32'h0);
        check_snap0("async_rst", 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_full("after_rst", -10, 1'b0);

        // 5. start held high: back-to-back reads with one idle cycle between
        begin
            int dcnt = 0;
            int d_at [2] = '{-1, -1};
            start0 = 1'b1;
            for (int n = 0; n < 500; n++) begin
                @(negedge clk);
                if (done0 === 1'b1) begin
                    if (dcnt < 2) d_at[dcnt] = n;
                    dcnt++;
                end
                if (n == 201) check("b2b_idle", 32'({addr0, en0, busy0, done0}), 32'h0);
                if (n == 202) check("b2b_restart", 32'({addr0, en0, busy0}), 32'({6'd1, 1'b1, 1'b1}));
            end
            start0 = 1'b0;
            check("b2b_done_count", 32'(dcnt), 32'd2);
            check("b2b_done1_at", 32'(d_at[0]), 32'd200);
            check("b2b_done2_at", 32'(d_at[1]), 32'd402);
            check_snap0("b2b", 1'b0);
            // let the third sequence that started at n=403 drain
            repeat (250) @(negedge clk);
            check("b2b_drained", 32'({addr0, en0, busy0}), 32'h0);
        end

        // 6. one tick per step
        begin
            int bad = 0;
            int dcnt = 0;
            int d_at = -1;
            start1 = 1'b1;
            for (int n = 0; n <= 60; n++) begin
                @(negedge clk);
                if (n == 0) start1 = 1'b0;
                if (n < 50 && (addr1 != 6'(n + 1) || en1 !== 1'b1)) bad++;
                if (done1 === 1'b1) begin
                    dcnt++;
                    if (d_at < 0) d_at = n;
                end
            end
            check("t1_addr_seq", 32'(bad), 32'h0);
            check("t1_done_count", 32'(dcnt), 32'd1);
            check("t1_done_at", 32'(d_at), 32'd50);
            check("t1_dv", 32'(dv1), 32'h1);
            for (int i = 0; i < 9; i++)
                check($sformatf("t1_snap%0d", i), 32'(snap1[i]), 32'(expv[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
